// File: rtl/mac1d_win_feeder.sv
// Streaming window generator for the 1D MAC stage: keeps a winW-deep per-line shift
// window and emits one packed window per accepted sample once the window is full.
module mac1d_win_feeder #(
   parameter int unsigned winW     = 3,
   parameter int unsigned winDataW = 8,
   localparam int unsigned cntW    = $clog2(winW + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [winDataW-1:0]      in_data,
   input  logic                     in_eol,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [winW*winDataW-1:0] out_Arr,
   output logic                     out_eol
);

   typedef enum logic [0:0] {StFill, StStream} state_e;

   state_e                   state_q;
   logic [cntW-1:0]          fill_q;
   logic [cntW-1:0]          fill_inc;
   logic [winW*winDataW-1:0] win_q;
   logic [winW*winDataW-1:0] win_shift;
   logic                     accept;
   logic                     load;

   assign in_ready = rst_n && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      fill_inc = fill_q;
      if (fill_q != cntW'(winW)) begin
         fill_inc = fill_q + cntW'(1);
      end
      // Newest sample enters the top slot; slot 0 (lowest bits) is the oldest.
      win_shift = {in_data, win_q[winW*winDataW-1:winDataW]};
      load      = (state_q == StStream) || (fill_inc == cntW'(winW));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFill;
         fill_q    <= '0;
         win_q     <= '0;
         out_valid <= 1'b0;
         out_Arr   <= '0;
         out_eol   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (load) begin
               out_valid <= 1'b1;
               out_Arr   <= win_shift;
               out_eol   <= in_eol;
            end
            // End of line: the window decision above is made first, then nothing
            // from this line may leak into the next one.
            if (in_eol) begin
               state_q <= StFill;
               fill_q  <= '0;
               win_q   <= '0;
            end else begin
               state_q <= load ? StStream : StFill;
               fill_q  <= fill_inc;
               win_q   <= win_shift;
            end
         end
      end
   end

endmodule
